// File: rtl/collatz_engine.sv
// collatz_engine: sequential Collatz evaluator with a start/busy/done handshake.
// One Collatz step per clock. The engine reports the stopping time, the peak
// value reached, and flags that say why a run ended: overflow, timeout or
// invalid input. Every output is registered.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for start; results and flags hold the last run's values
// RUN   | stepping cur once per clock until it reaches 1, overflows or times out

module collatz_engine #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps,
    output logic [WIDTH-1:0] peak,
    output logic [WIDTH-1:0] cur,
    output logic             overflow,
    output logic             timeout,
    output logic             invalid
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH+1:0] ONE_EXT  = {{(WIDTH + 1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH - 1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] STEP_ONE = {{(CNT_W - 1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] STEP_MAX = '1;

    state_t           state;
    logic [WIDTH+1:0] cur_ext;
    logic [WIDTH+1:0] triple;
    logic             triple_ovf;
    logic [WIDTH-1:0] next_val;
    logic             at_one;
    logic             at_limit;

    // Next Collatz value. 3*cur+1 is formed two bits wider than cur, so any
    // carry into the top two bits means the odd step cannot be represented.
    always_comb begin
        cur_ext    = {2'b00, cur};
        triple     = (cur_ext << 1) + cur_ext + ONE_EXT;
        triple_ovf = |triple[WIDTH+1:WIDTH];
        next_val   = cur[0] ? triple[WIDTH-1:0] : (cur >> 1);
        at_one     = (cur == ONE_VAL);
        at_limit   = (steps == STEP_MAX);
    end

    // Control FSM and result registers. busy mirrors RUN; done is a one-cycle
    // pulse. Termination conditions are checked in order: reached 1, step
    // counter exhausted, odd step would overflow. The early exits leave cur,
    // peak and steps untouched so they describe the last legal state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            steps    <= '0;
            peak     <= '0;
            cur      <= '0;
            overflow <= 1'b0;
            timeout  <= 1'b0;
            invalid  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        steps    <= '0;
                        overflow <= 1'b0;
                        timeout  <= 1'b0;
                        if (n == '0) begin
                            // Zero never reaches 1; finish at once without entering RUN.
                            cur     <= '0;
                            peak    <= '0;
                            invalid <= 1'b1;
                            done    <= 1'b1;
                        end else begin
                            cur     <= n;
                            peak    <= n;
                            invalid <= 1'b0;
                            busy    <= 1'b1;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (at_one) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (at_limit) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (cur[0] && triple_ovf) begin
                        overflow <= 1'b1;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cur   <= next_val;
                        steps <= steps + STEP_ONE;
                        if (next_val > peak) begin
                            peak <= next_val;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collatz_engine.sv
// Scoreboard bench for collatz_engine. Three instances cover the parameter
// sets exercised: A (8/8), B (16/4, short step counter) and C (16/8, reset test).
// Stimulus pushes hand-computed results; per-instance monitors pop on done.

module tb_collatz_engine;

    typedef struct {
        int steps;
        int peak;
        int cur;
        bit ov;
        bit to;
        bit inv;
        int dcyc;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    exp_t ea, eb, ec;

    logic        rst_a, start_a, busy_a, done_a, ov_a, to_a, inv_a;
    logic [7:0]  n_a, steps_a, peak_a, cur_a;
    logic        rst_b, start_b, busy_b, done_b, ov_b, to_b, inv_b;
    logic [15:0] n_b, peak_b, cur_b;
    logic [3:0]  steps_b;
    logic        rst_c, start_c, busy_c, done_c, ov_c, to_c, inv_c;
    logic [15:0] n_c, peak_c, cur_c;
    logic [7:0]  steps_c;

    collatz_engine #(.WIDTH(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .n(n_a), .busy(busy_a), .done(done_a),
        .steps(steps_a), .peak(peak_a), .cur(cur_a), .overflow(ov_a), .timeout(to_a), .invalid(inv_a)
    );
    collatz_engine #(.WIDTH(16), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .n(n_b), .busy(busy_b), .done(done_b),
        .steps(steps_b), .peak(peak_b), .cur(cur_b), .overflow(ov_b), .timeout(to_b), .invalid(inv_b)
    );
    collatz_engine #(.WIDTH(16), .CNT_W(8)) dut_c (
        .clk(clk), .rst(rst_c), .start(start_c), .n(n_c), .busy(busy_c), .done(done_c),
        .steps(steps_c), .peak(peak_c), .cur(cur_c), .overflow(ov_c), .timeout(to_c), .invalid(inv_c)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge k, cyc reads k.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endfunction

    function automatic int get_busy(input int w);
        case (w)
            0:       return int'(busy_a);
            1:       return int'(busy_b);
            default: return int'(busy_c);
        endcase
    endfunction

    function automatic int q_size(input int w);
        case (w)
            0:       return q_a.size();
            1:       return q_b.size();
            default: return q_c.size();
        endcase
    endfunction

    // Monitors: compare one scoreboard entry per done pulse.
    always @(negedge clk) begin
        if (!rst_a && done_a) begin
            if (q_a.size() == 0) check("a_spurious_done", 1, 0);
            else begin
                ea = q_a.pop_front();
                check("a_done_cycle", cyc, ea.dcyc);
                check("a_steps", int'(steps_a), ea.steps);
                check("a_peak", int'(peak_a), ea.peak);
                check("a_cur", int'(cur_a), ea.cur);
                check("a_flags_ov_to_inv", int'({ov_a, to_a, inv_a}), int'({ea.ov, ea.to, ea.inv}));
                check("a_busy_at_done", int'(busy_a), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b && done_b) begin
            if (q_b.size() == 0) check("b_spurious_done", 1, 0);
            else begin
                eb = q_b.pop_front();
                check("b_done_cycle", cyc, eb.dcyc);
                check("b_steps", int'(steps_b), eb.steps);
                check("b_peak", int'(peak_b), eb.peak);
                check("b_cur", int'(cur_b), eb.cur);
                check("b_flags_ov_to_inv", int'({ov_b, to_b, inv_b}), int'({eb.ov, eb.to, eb.inv}));
                check("b_busy_at_done", int'(busy_b), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_c && done_c) begin
            if (q_c.size() == 0) check("c_spurious_done", 1, 0);
            else begin
                ec = q_c.pop_front();
                check("c_done_cycle", cyc, ec.dcyc);
                check("c_steps", int'(steps_c), ec.steps);
                check("c_peak", int'(peak_c), ec.peak);
                check("c_cur", int'(cur_c), ec.cur);
                check("c_flags_ov_to_inv", int'({ov_c, to_c, inv_c}), int'({ec.ov, ec.to, ec.inv}));
                check("c_busy_at_done", int'(busy_c), 0);
            end
        end
    end

    // Issue one start, record the expected result with its done cycle
    // (start edge + lat), and check busy in the cycle after the start edge.
    task automatic issue(input int w, input int nval, input int s, input int p, input int c,
                         input bit ov, input bit to, input bit inv, input int lat);
        exp_t e;
        @(negedge clk);
        case (w)
            0:       begin n_a = 8'(nval);  start_a = 1'b1; end
            1:       begin n_b = 16'(nval); start_b = 1'b1; end
            default: begin n_c = 16'(nval); start_c = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        e = '{s, p, c, ov, to, inv, cyc + lat};
        case (w)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
        @(negedge clk);
        check("busy_after_start", get_busy(w), inv ? 0 : 1);
    endtask

    // Wait (bounded) until the monitor has consumed every expected result.
    task automatic drain(input int w, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (q_size(w) == 0) break;
            @(negedge clk);
        end
        if (q_size(w) != 0) begin
            check("done_wait_expired_pending", q_size(w), 0);
            case (w)
                0:       q_a.delete();
                1:       q_b.delete();
                default: q_c.delete();
            endcase
        end
    endtask

    int c0;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        n_a = '0; n_b = '0; n_c = '0;
        #23;
        check("rst_a_ctrl_flags", int'({busy_a, done_a, ov_a, to_a, inv_a}), 0);
        check("rst_a_data", int'({steps_a, peak_a, cur_a}), 0);
        check("rst_b_ctrl_flags", int'({busy_b, done_b, ov_b, to_b, inv_b}), 0);
        check("rst_c_ctrl_flags", int'({busy_c, done_c, ov_c, to_c, inv_c}), 0);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // A: normal, overflow, edge inputs, flag clearing
        issue(0, 6,  8,  16,  1,   0, 0, 0, 9);   drain(0, 40);
        issue(0, 27, 11, 214, 107, 1, 0, 0, 12);  drain(0, 40);
        issue(0, 3,  7,  16,  1,   0, 0, 0, 8);   drain(0, 40);
        issue(0, 1,  0,  1,   1,   0, 0, 0, 1);   drain(0, 40);
        issue(0, 85, 0,  85,  85,  1, 0, 0, 1);   drain(0, 40);
        issue(0, 0,  0,  0,   0,   0, 0, 1, 0);
        check("a_invalid_busy_low", int'(busy_a), 0);
        drain(0, 40);
        issue(0, 6,  8,  16,  1,   0, 0, 0, 9);   drain(0, 40);

        // A: start pulse with n=3 mid-run must be ignored
        issue(0, 6,  8,  16,  1,   0, 0, 0, 9);
        repeat (2) @(negedge clk);
        n_a = 8'd3; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        drain(0, 40);

        // A: start held high -> runs separated by one idle cycle
        @(negedge clk);
        n_a = 8'd6; start_a = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        q_a.push_back('{8, 16, 1, 1'b0, 1'b0, 1'b0, c0 + 9});
        q_a.push_back('{8, 16, 1, 1'b0, 1'b0, 1'b0, c0 + 19});
        repeat (12) @(posedge clk);
        #1;
        start_a = 1'b0;
        drain(0, 40);

        // B: timeouts on a 4-bit step counter, and a run that fits
        issue(1, 27, 15, 484, 242, 0, 1, 0, 16);  drain(1, 40);
        issue(1, 7,  15, 52,  2,   0, 1, 0, 16);  drain(1, 40);
        issue(1, 16, 4,  16,  1,   0, 0, 0, 5);   drain(1, 40);

        // C: asynchronous reset mid-run, then a clean run
        @(negedge clk);
        n_c = 16'd27; start_c = 1'b1;
        @(posedge clk);
        #1;
        start_c = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("c_steps_before_reset", int'(steps_c), 50);
        #2;
        rst_c = 1'b1;
        #1;
        check("c_async_rst_ctrl_flags", int'({busy_c, done_c, ov_c, to_c, inv_c}), 0);
        check("c_async_rst_steps", int'(steps_c), 0);
        check("c_async_rst_peak", int'(peak_c), 0);
        check("c_async_rst_cur", int'(cur_c), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_c = 1'b0;
        issue(2, 6, 8, 16, 1, 0, 0, 0, 9);
        drain(2, 40);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
